// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Moore-style sequencer for the multi-cycle extended MIPS datapath
//            (base set plus ori, jsp, jmxor, bgezal, baln, balrv). One shared
//            memory and one shared ALU are time-multiplexed across the states.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SP_REG    : register index the datapath forces onto rs for jsp (29)
//   LINK_REG  : link register selected by regdest=10 (31)
// Ports
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous, active-high
//   instr        in  32   IR contents (opcode, rs, rt, rd, funct)
//   dataa        in  32   register A, only the sign bit is used
//   status       in   3   {Z,N,V} flags
//   pcwrite .. rssel_sp  out 1 each   write/read strobes
//   iord         out  2   memory address: 00 PC, 01 ALUOut, 10 A
//   regdest      out  2   write register: 00 rt, 01 rd, 10 LINK_REG
//   memtoreg     out  2   write data: 00 ALUOut, 01 MDR, 10 PC
//   alusrca      out  1   ALU A: 0 PC, 1 A
//   alusrcb      out  2   ALU B: 00 B, 01 4, 10 simm, 11 simm<<2
//   aluop        out  3   000 add, 001 sub, 010 funct, 011 or-zimm, 100 xor
//   pcsource     out  3   000 ALU, 001 ALUOut, 010 jump target, 011 MDR, 100 A
//   trap         out  1   illegal-opcode indication
//   state        out  5   current state, debug only
// Build option
//   MULTICYCLE_CONTROL_TRAP_EN : when defined, an illegal opcode parks the
//   sequencer in ILLEGAL with trap=1 until reset; otherwise ILLEGAL is a
//   one-cycle NOP and trap is constant 0.
// ============================================================================
module multicycle_control #(
  parameter int SP_REG   = 29,
  parameter int LINK_REG = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] dataa,
  input  logic [2:0]  status,
  output logic        pcwrite,
  output logic        pcwritecond,
  output logic        irwrite,
  output logic        regwrite,
  output logic        memread,
  output logic        memwrite,
  output logic        rssel_sp,
  output logic [1:0]  iord,
  output logic [1:0]  regdest,
  output logic [1:0]  memtoreg,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [2:0]  aluop,
  output logic [2:0]  pcsource,
  output logic        trap,
  output logic [4:0]  state
);

  typedef enum logic [4:0] {
    S_RST     = 5'd0,
    S_FETCH   = 5'd1,
    S_DECODE  = 5'd2,
    S_MADDR   = 5'd3,
    S_MRD     = 5'd4,
    S_MWB     = 5'd5,
    S_MWR     = 5'd6,
    S_REXEC   = 5'd7,
    S_RWB     = 5'd8,
    S_OEXEC   = 5'd9,
    S_OWB     = 5'd10,
    S_BEQ     = 5'd11,
    S_XADDR   = 5'd12,
    S_JMEM    = 5'd13,
    S_JJUMP   = 5'd14,
    S_BGEZ    = 5'd15,
    S_BALN    = 5'd16,
    S_BALRV   = 5'd17,
    S_ILLEGAL = 5'd18
  } state_t;

  localparam logic [5:0] C_OP_RTYPE = 6'd0;
  localparam logic [5:0] C_OP_BEQ   = 6'd4;
  localparam logic [5:0] C_OP_ORI   = 6'd13;
  localparam logic [5:0] C_OP_JSP   = 6'd18;
  localparam logic [5:0] C_OP_BALN  = 6'd27;
  localparam logic [5:0] C_OP_LW    = 6'd35;
  localparam logic [5:0] C_OP_SW    = 6'd43;
  localparam logic [5:0] C_FN_BALRV = 6'd22;
  localparam logic [5:0] C_FN_JMXOR = 6'd34;

  localparam logic [2:0] C_ALU_ADD = 3'b000;
  localparam logic [2:0] C_ALU_SUB = 3'b001;
  localparam logic [2:0] C_ALU_FN  = 3'b010;
  localparam logic [2:0] C_ALU_ORI = 3'b011;
  localparam logic [2:0] C_ALU_XOR = 3'b100;

  state_t state_q, state_d;

  logic [5:0] w_op;
  logic [4:0] w_rt;
  logic [4:0] w_rd;
  logic [5:0] w_fn;

  assign w_op = instr[31:26];
  assign w_rt = instr[20:16];
  assign w_rd = instr[15:11];
  assign w_fn = instr[5:0];

  // Register indices live in the datapath muxes; they are carried here only
  // so the configuration is visible alongside the control encoding.
  logic [30:0] w_unused_bits;
  assign w_unused_bits = {5'(SP_REG), 5'(LINK_REG), instr[25:21], instr[10:6],
                          dataa[30:20], status[2]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_RST;
    else       state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d     = state_q;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    irwrite     = 1'b0;
    regwrite    = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    rssel_sp    = 1'b0;
    iord        = 2'b00;
    regdest     = 2'b00;
    memtoreg    = 2'b00;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = C_ALU_ADD;
    pcsource    = 3'b000;
    trap        = 1'b0;

    case (state_q)
      S_RST: state_d = S_FETCH;

      S_FETCH: begin
        memread = 1'b1;
        irwrite = 1'b1;
        alusrcb = 2'b01;
        pcwrite = 1'b1;
        state_d = S_DECODE;
      end

      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut.
        alusrcb  = 2'b11;
        rssel_sp = (w_op == C_OP_JSP);
        case (w_op)
          C_OP_RTYPE: begin
            if (w_fn == C_FN_BALRV)                     state_d = S_BALRV;
            else if (w_fn == C_FN_JMXOR && w_rd == 5'd0) state_d = S_XADDR;
            else                                         state_d = S_REXEC;
          end
          // lw with rt=0 would be a useless load; that encoding is bgezal.
          C_OP_LW:   state_d = (w_rt != 5'd0) ? S_MADDR : S_BGEZ;
          C_OP_SW:   state_d = S_MADDR;
          C_OP_BEQ:  state_d = S_BEQ;
          C_OP_ORI:  state_d = S_OEXEC;
          C_OP_JSP:  state_d = S_JMEM;
          C_OP_BALN: state_d = S_BALN;
          default:   state_d = S_ILLEGAL;
        endcase
      end

      S_MADDR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (w_op == C_OP_LW) ? S_MRD : S_MWR;
      end

      S_MRD: begin
        memread = 1'b1;
        iord    = 2'b01;
        state_d = S_MWB;
      end

      S_MWB: begin
        regwrite = 1'b1;
        memtoreg = 2'b01;
        state_d  = S_FETCH;
      end

      S_MWR: begin
        memwrite = 1'b1;
        iord     = 2'b01;
        state_d  = S_FETCH;
      end

      S_REXEC: begin
        alusrca = 1'b1;
        aluop   = C_ALU_FN;
        state_d = S_RWB;
      end

      S_RWB: begin
        regwrite = 1'b1;
        regdest  = 2'b01;
        state_d  = S_FETCH;
      end

      S_OEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = C_ALU_ORI;
        state_d = S_OWB;
      end

      S_OWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_BEQ: begin
        alusrca     = 1'b1;
        aluop       = C_ALU_SUB;
        pcwritecond = 1'b1;
        pcsource    = 3'b001;
        state_d     = S_FETCH;
      end

      S_XADDR: begin
        alusrca = 1'b1;
        aluop   = C_ALU_XOR;
        state_d = S_JMEM;
      end

      S_JMEM: begin
        // jsp reads through A (rs forced to SP); jmxor through ALUOut.
        memread = 1'b1;
        iord    = (w_op == C_OP_JSP) ? 2'b10 : 2'b01;
        state_d = S_JJUMP;
      end

      S_JJUMP: begin
        pcwrite  = 1'b1;
        pcsource = 3'b011;
        // PC still holds PC+4 here, so memtoreg=10 writes the return address.
        if (w_op == C_OP_RTYPE) begin
          regwrite = 1'b1;
          regdest  = 2'b10;
          memtoreg = 2'b10;
        end
        state_d = S_FETCH;
      end

      S_BGEZ: begin
        if (!dataa[31]) begin
          pcwrite  = 1'b1;
          pcsource = 3'b001;
          regwrite = 1'b1;
          regdest  = 2'b10;
          memtoreg = 2'b10;
        end
        state_d = S_FETCH;
      end

      S_BALN: begin
        if (status[1]) begin
          pcwrite  = 1'b1;
          pcsource = 3'b010;
          regwrite = 1'b1;
          regdest  = 2'b10;
          memtoreg = 2'b10;
        end
        state_d = S_FETCH;
      end

      S_BALRV: begin
        if (status[0]) begin
          pcwrite  = 1'b1;
          pcsource = 3'b100;
          regwrite = 1'b1;
          regdest  = 2'b01;
          memtoreg = 2'b10;
        end
        state_d = S_FETCH;
      end

      S_ILLEGAL: begin
`ifdef MULTICYCLE_CONTROL_TRAP_EN
        trap    = 1'b1;
        state_d = S_ILLEGAL;
`else
        state_d = S_FETCH;
`endif
      end

      default: state_d = S_RST;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Scoreboard bench for multicycle_control. A driver issues whole
//            instructions and queues the per-cycle control words the
//            instruction must produce; a monitor pops one word per cycle on
//            the falling edge and compares it with the DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic [31:0] dataa;
  logic [2:0]  status;
  logic        pcwrite, pcwritecond, irwrite, regwrite, memread, memwrite, rssel_sp;
  logic [1:0]  iord, regdest, memtoreg, alusrcb;
  logic        alusrca, trap;
  logic [2:0]  aluop, pcsource;
  logic [4:0]  state;

  multicycle_control #(.SP_REG(29), .LINK_REG(31)) dut (
    .clk(clk), .reset(reset), .instr(instr), .dataa(dataa), .status(status),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .irwrite(irwrite),
    .regwrite(regwrite), .memread(memread), .memwrite(memwrite),
    .rssel_sp(rssel_sp), .iord(iord), .regdest(regdest), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource),
    .trap(trap), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcwrite, pcwritecond, irwrite, regwrite, memread, memwrite, rssel_sp;
    logic [1:0] iord, regdest, memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop, pcsource;
    logic       trap;
  } ctl_t;

  typedef struct packed {
    ctl_t c;
    logic rst;   // word belongs to a reset cycle: state must also read 0
  } exp_t;

  ctl_t act;
  always_comb act = {pcwrite, pcwritecond, irwrite, regwrite, memread, memwrite,
                     rssel_sp, iord, regdest, memtoreg, alusrca, alusrcb, aluop,
                     pcsource, trap};

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic ctl_t zero();
    zero = '0;
  endfunction

  task automatic push(input ctl_t c);
    q.push_back({c, 1'b0});
  endtask

  task automatic push_rst();
    q.push_back({zero(), 1'b1});
  endtask

  // --------------------------------------------------------------------------
  // Reference model: the control-word sequence of one instruction, written
  // straight from the per-instruction micro-step description.
  // --------------------------------------------------------------------------
  task automatic model(input logic [31:0] ins, input logic [31:0] a,
                       input logic [2:0] st, output int n, output bit halt);
    logic [5:0] op, fn;
    logic [4:0] rt, rd;
    ctl_t c;
    op = ins[31:26]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
    halt = 1'b0;
    // fetch: IR <- mem[PC], PC <- PC+4
    c = zero(); c.memread = 1; c.irwrite = 1; c.alusrcb = 2'b01; c.pcwrite = 1; push(c);
    // decode: ALUOut <- PC + simm<<2
    c = zero(); c.alusrcb = 2'b11; c.rssel_sp = (op == 6'd18); push(c);
    if (op == 6'd0 && fn == 6'd22) begin                  // balrv
      c = zero();
      if (st[0]) begin c.pcwrite = 1; c.pcsource = 3'b100; c.regwrite = 1; c.regdest = 2'b01; c.memtoreg = 2'b10; end
      push(c); n = 3;
    end else if (op == 6'd0 && fn == 6'd34 && rd == 5'd0) begin  // jmxor
      c = zero(); c.alusrca = 1; c.aluop = 3'b100; push(c);
      c = zero(); c.memread = 1; c.iord = 2'b01; push(c);
      c = zero(); c.pcwrite = 1; c.pcsource = 3'b011; c.regwrite = 1; c.regdest = 2'b10; c.memtoreg = 2'b10; push(c);
      n = 5;
    end else if (op == 6'd0) begin                        // R-type
      c = zero(); c.alusrca = 1; c.aluop = 3'b010; push(c);
      c = zero(); c.regwrite = 1; c.regdest = 2'b01; push(c);
      n = 4;
    end else if (op == 6'd35 && rt != 5'd0) begin         // lw
      c = zero(); c.alusrca = 1; c.alusrcb = 2'b10; push(c);
      c = zero(); c.memread = 1; c.iord = 2'b01; push(c);
      c = zero(); c.regwrite = 1; c.memtoreg = 2'b01; push(c);
      n = 5;
    end else if (op == 6'd35) begin                       // bgezal
      c = zero();
      if (!a[31]) begin c.pcwrite = 1; c.pcsource = 3'b001; c.regwrite = 1; c.regdest = 2'b10; c.memtoreg = 2'b10; end
      push(c); n = 3;
    end else if (op == 6'd43) begin                       // sw
      c = zero(); c.alusrca = 1; c.alusrcb = 2'b10; push(c);
      c = zero(); c.memwrite = 1; c.iord = 2'b01; push(c);
      n = 4;
    end else if (op == 6'd4) begin                        // beq
      c = zero(); c.alusrca = 1; c.aluop = 3'b001; c.pcwritecond = 1; c.pcsource = 3'b001; push(c);
      n = 3;
    end else if (op == 6'd13) begin                       // ori
      c = zero(); c.alusrca = 1; c.alusrcb = 2'b10; c.aluop = 3'b011; push(c);
      c = zero(); c.regwrite = 1; push(c);
      n = 4;
    end else if (op == 6'd18) begin                       // jsp
      c = zero(); c.memread = 1; c.iord = 2'b10; push(c);
      c = zero(); c.pcwrite = 1; c.pcsource = 3'b011; push(c);
      n = 4;
    end else if (op == 6'd27) begin                       // baln
      c = zero();
      if (st[1]) begin c.pcwrite = 1; c.pcsource = 3'b010; c.regwrite = 1; c.regdest = 2'b10; c.memtoreg = 2'b10; end
      push(c); n = 3;
    end else begin                                        // illegal
`ifdef MULTICYCLE_CONTROL_TRAP_EN
      c = zero(); c.trap = 1;
      for (int k = 0; k < 10; k++) push(c);
      n = 12; halt = 1'b1;
`else
      push(zero()); n = 3;
`endif
    end
  endtask

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  task automatic check(input string name, input ctl_t exp_c, input bit exp_rst);
    n_cmp++;
    if (act !== exp_c || (exp_rst && state !== 5'd0)) begin
      n_err++;
      $display("FAIL %s t=%0t: actual ctl=%h state=%0d, required ctl=%h%s",
               name, $time, act, state, exp_c, exp_rst ? " state=0" : "");
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      check(e.rst ? "reset_cycle" : "ctl_cycle", e.c, e.rst);
    end
  end

  // --------------------------------------------------------------------------
  // Driver (all tasks start and end just after a rising edge)
  // --------------------------------------------------------------------------
  task automatic do_reset();
    reset = 1'b1; push_rst();
    @(posedge clk); #1; push_rst();
    @(posedge clk); #1; reset = 1'b0; push_rst();
    @(posedge clk); #1;
  endtask

  // Condition inputs carry their intended value only in cycle 2 (the
  // conditional state); other cycles see noise.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] a, input logic [2:0] st);
    int n; bit halt;
    model(ins, a, st, n, halt);
    instr = ins;
    for (int k = 0; k < n; k++) begin
      dataa  = (k == 2) ? a  : $urandom;
      status = (k == 2) ? st : 3'($urandom);
      @(posedge clk); #1;
    end
    if (halt) do_reset();
  endtask

  // lw interrupted by reset while in the memory-read cycle.
  task automatic abort_lw();
    int n; bit halt;
    ctl_t c;
    model({6'd35, 5'd9, 5'd8, 16'd4}, 32'h0, 3'b000, n, halt);
    instr = {6'd35, 5'd9, 5'd8, 16'd4};
    repeat (3) begin @(posedge clk); #1; end
    c = zero(); c.memread = 1; c.iord = 2'b01;
    check("mrd_before_abort", c, 1'b0);
    q.delete();
    do_reset();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0]  op;
    r = $urandom;
    case ($urandom_range(0, 10))
      0: begin r[31:26] = 6'd35; if (r[20:16] == 5'd0) r[20:16] = 5'd1; end
      1: r[31:26] = 6'd43;
      2: begin
        r[31:26] = 6'd0;
        if (r[5:0] == 6'd22) r[5:0] = 6'd32;
        if (r[5:0] == 6'd34 && r[15:11] == 5'd0) r[15:11] = 5'd1;
      end
      3: begin r[31:26] = 6'd0; r[15:11] = 5'd0; r[5:0] = 6'd34; end
      4: r[31:26] = 6'd13;
      5: r[31:26] = 6'd4;
      6: r[31:26] = 6'd18;
      7: begin r[31:26] = 6'd35; r[20:16] = 5'd0; end
      8: r[31:26] = 6'd27;
      9: begin r[31:26] = 6'd0; r[5:0] = 6'd22; end
      default: begin
        op = 6'($urandom);
        while (op == 6'd0 || op == 6'd4 || op == 6'd13 || op == 6'd18 ||
               op == 6'd27 || op == 6'd35 || op == 6'd43) op = 6'($urandom);
        r[31:26] = op;
      end
    endcase
    return r;
  endfunction

  initial begin
    reset  = 1'b1;
    instr  = 32'h0;
    dataa  = 32'h0;
    status = 3'b000;
    @(posedge clk); #1;
    do_reset();

    // Directed cases
    run_instr({6'd35, 5'd9, 5'd8, 16'd4}, 32'h0, 3'b000);            // lw $8,4($9)
    run_instr({6'd35, 5'd9, 5'd0, 16'd4}, 32'hFFFF_FFFF, 3'b000);    // bgezal not taken
    run_instr({6'd35, 5'd9, 5'd0, 16'd4}, 32'h0000_0001, 3'b000);    // bgezal taken
    run_instr({6'd0, 5'd3, 5'd4, 5'd0, 5'd0, 6'd34}, 32'h0, 3'b000); // jmxor
    run_instr({6'd0, 5'd3, 5'd4, 5'd5, 5'd0, 6'd34}, 32'h0, 3'b000); // sub
    run_instr({6'd18, 26'h0000010}, 32'h0, 3'b000);                  // jsp
    run_instr({6'd27, 26'h0000100}, 32'h0, 3'b010);                  // baln taken
    run_instr({6'd27, 26'h0000100}, 32'h0, 3'b101);                  // baln not taken
    run_instr({6'd0, 5'd2, 5'd0, 5'd7, 5'd0, 6'd22}, 32'h0, 3'b000); // balrv not taken
    run_instr({6'd0, 5'd2, 5'd0, 5'd7, 5'd0, 6'd22}, 32'h0, 3'b001); // balrv taken
    run_instr({6'd43, 5'd1, 5'd2, 16'h8}, 32'h0, 3'b000);            // sw
    run_instr({6'd4, 5'd1, 5'd2, 16'h8}, 32'h0, 3'b000);             // beq
    run_instr({6'd13, 5'd1, 5'd2, 16'hFF}, 32'h0, 3'b000);           // ori
    abort_lw();
    run_instr({6'd63, 26'h0}, 32'h0, 3'b000);                        // illegal
    run_instr({6'd35, 5'd9, 5'd8, 16'd4}, 32'h0, 3'b000);            // recovers

    // Randomized stream
    for (int i = 0; i < 150; i++)
      run_instr(rand_instr(), $urandom, 3'($urandom));

    @(negedge clk); #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: actual %0d entries left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
